// File: rtl/axi_wr_slot_arbiter.sv
// Per-slave AW/W/B burst ownership arbiter for a 2-master write crossbar.
// One master owns the slave from AW acceptance through the B response.
// The owner is chosen round-robin, or m1 wins every tie when PRIORITY_M1 is set.
// The block also flags WLAST placed against AWLEN and drops a stalled burst
// through a watchdog.
//
// Handshake note: every *_fire input is the slave-side VALID && READY for that
// channel, and it counts only in the state that owns that channel.
// A fire in any other state is ignored, except that it still clears the
// watchdog. The gates are decoded from state alone. This lets the crossbar
// route VALID/READY without any combinational path from req.
module axi_wr_slot_arbiter #(
  parameter bit PRIORITY_M1 = 1'b0,
  parameter int TIMEOUT_W   = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [7:0] aw_len,
  input  logic       aw_fire,
  input  logic       w_fire,
  input  logic       w_last,
  input  logic       b_fire,
  output logic [1:0] grant,
  output logic       owner,
  output logic       aw_gate,
  output logic       w_gate,
  output logic       b_gate,
  output logic       busy,
  output logic       err_wlast,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  // The watchdog expires on the cycle in which it would reach 2**TIMEOUT_W-1.
  // A burst that makes no progress therefore keeps its grant for
  // 2**TIMEOUT_W-1 cycles.
  localparam logic [TIMEOUT_W-1:0] WDOG_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
  localparam logic [TIMEOUT_W-1:0] WDOG_ONE  = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

  state_t               state, state_nx;
  logic [1:0]           grant_nx;
  logic                 owner_nx;
  logic                 last_owner, last_owner_nx;
  logic [7:0]           len, len_nx;
  logic [8:0]           beat, beat_nx;
  logic [TIMEOUT_W-1:0] wdog, wdog_nx;
  logic                 err_nx, timeout_nx;
  logic                 winner;
  logic                 any_fire;

  assign any_fire = aw_fire | w_fire | b_fire;

  // Channel gates and busy are pure decodes of the registered state.
  assign aw_gate = (state == ADDR);
  assign w_gate  = (state == DATA);
  assign b_gate  = (state == RESP);
  assign busy    = (state != IDLE);

  // Choose the tie winner: fixed m1, or the master that did not own the slave last.
  always_comb begin
    winner = 1'b0;
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = PRIORITY_M1 ? 1'b1 : ~last_owner;
      default: winner = 1'b0;
    endcase
  end

  // Next-state, burst tracking, WLAST check and watchdog.
  always_comb begin
    state_nx      = state;
    grant_nx      = grant;
    owner_nx      = owner;
    last_owner_nx = last_owner;
    len_nx        = len;
    beat_nx       = beat;
    wdog_nx       = wdog;
    err_nx        = 1'b0;
    timeout_nx    = 1'b0;

    case (state)
      IDLE: begin
        if (req != 2'b00) begin
          state_nx = ADDR;
          owner_nx = winner;
          grant_nx = winner ? 2'b10 : 2'b01;
        end
      end
      ADDR: begin
        if (aw_fire) begin
          len_nx   = aw_len;
          beat_nx  = 9'd0;
          state_nx = DATA;
        end
      end
      DATA: begin
        if (w_fire) begin
          beat_nx = beat + 9'd1;
          err_nx  = w_last != (beat == {1'b0, len});
          if (w_last) begin
            state_nx = RESP;
          end
        end
      end
      RESP: begin
        if (b_fire) begin
          last_owner_nx = owner;
          grant_nx      = 2'b00;
          state_nx      = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase

    if (state == IDLE || any_fire || state_nx != state) begin
      wdog_nx = '0;
    end else if (wdog == WDOG_LAST) begin
      timeout_nx    = 1'b1;
      last_owner_nx = owner;
      grant_nx      = 2'b00;
      state_nx      = IDLE;
      wdog_nx       = '0;
    end else begin
      wdog_nx = wdog + WDOG_ONE;
    end
  end

  // State and output registers; reset returns to idle with m0 favoured.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= 2'b00;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      len        <= 8'd0;
      beat       <= 9'd0;
      wdog       <= '0;
      err_wlast  <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_nx;
      grant      <= grant_nx;
      owner      <= owner_nx;
      last_owner <= last_owner_nx;
      len        <= len_nx;
      beat       <= beat_nx;
      wdog       <= wdog_nx;
      err_wlast  <= err_nx;
      timeout    <= timeout_nx;
    end
  end

endmodule
